// File: rtl/state_dump_sequencer.sv
// state_dump_sequencer: walks the register file then a memory window, emitting each word as a valid/ready beat
module state_dump_sequencer #(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned REG_AW    = 5,
  parameter logic [31:0] MEM_BASE  = 32'h10010000,
  parameter int unsigned MEM_WORDS = 5,
  parameter int unsigned DW        = 32,
  parameter int unsigned TIMEOUT   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [REG_AW-1:0] rf_addr,
  input  logic [DW-1:0]     rf_data,
  output logic [29:0]       mem_addr,
  input  logic [DW-1:0]     mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_kind,
  output logic [31:0]       out_addr,
  output logic [DW-1:0]     out_data,
  output logic              busy,
  output logic              finished,
  output logic [31:0]       cycle_count
);
  typedef enum logic [2:0] {IDLE, REG, MEM, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] idx_q, idx_d, cnt_q, cnt_d, addr_q, addr_d, len;
  logic [DW-1:0] data_q, data_d;
  logic valid_q, valid_d, kind_q, kind_d;
  logic walking, in_mem, more, last, load, trig;
  // next state: a phase switches on the edge that loads its last beat, so the stream has no bubble between phases
  always_comb begin
    in_mem   = state_q == MEM;
    walking  = state_q == REG || in_mem;
    len      = in_mem ? 32'(MEM_WORDS) : 32'(NUM_REGS);
    more     = idx_q < len;
    last     = idx_q + 32'd1 >= len;
    load     = walking && (!valid_q || out_ready) && more;
    trig     = start || (TIMEOUT != 0 && cnt_q == 32'(TIMEOUT) - 32'd1);
    rf_addr  = state_q == REG ? idx_q[REG_AW-1:0] : '0;
    mem_addr = in_mem ? MEM_BASE[31:2] + idx_q[29:0] : '0;
    cnt_d    = cnt_q + {31'd0, ~&cnt_q};
    state_d  = state_q;
    idx_d    = idx_q;
    valid_d  = valid_q && !out_ready;
    kind_d   = kind_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (state_q == IDLE && trig) begin
      state_d = REG;
      idx_d   = '0;
    end
    if (load) begin
      valid_d = 1'b1;
      kind_d  = in_mem;
      addr_d  = in_mem ? MEM_BASE + {idx_q[29:0], 2'b00} : idx_q;
      data_d  = in_mem ? mem_data : rf_data;
      idx_d   = idx_q + 32'd1;
    end
    if (walking && (!more || (load && last))) begin
      state_d = (state_q == REG && MEM_WORDS != 0) ? MEM : DRAIN;
      idx_d   = '0;
    end
    if (state_q == DRAIN && (!valid_q || out_ready)) state_d = DONE;
  end
  // state, index, output beat and cycle counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      kind_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      kind_q  <= kind_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end
  assign out_valid   = valid_q;
  assign out_kind    = kind_q;
  assign out_addr    = addr_q;
  assign out_data    = data_q;
  assign busy        = state_q == REG || state_q == MEM;
  assign finished    = state_q == DONE;
  assign cycle_count = cnt_q;
endmodule

// File: tb/tb_state_dump_sequencer.sv
// tb_state_dump_sequencer: model-checked dump streams for a default and a small timeout-triggered instance
module tb_state_dump_sequencer;
  localparam logic [31:0] BASE = 32'h10010000;
  typedef struct {logic kind; logic [31:0] addr; logic [31:0] data;} beat_t;
  typedef struct {int idx; logic kind; logic [31:0] addr; logic [31:0] data;} vec_t;

  logic clk = 0;
  always #5 clk = ~clk;

  logic reset, reset1, start, start1, out_ready, out_ready1;
  logic [4:0] rf_addr;
  logic [1:0] rf_addr1;
  logic [29:0] mem_addr, mem_addr1;
  logic [31:0] rf_data, mem_data, rf_data1, mem_data1, mem_byte;
  logic out_valid, out_kind, busy, finished, out_valid1, out_kind1, busy1, finished1;
  logic [31:0] out_addr, out_data, cycle_count, out_addr1, out_data1, cycle_count1;

  state_dump_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .rf_addr(rf_addr), .rf_data(rf_data),
    .mem_addr(mem_addr), .mem_data(mem_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_kind(out_kind), .out_addr(out_addr), .out_data(out_data), .busy(busy),
    .finished(finished), .cycle_count(cycle_count));

  state_dump_sequencer #(.NUM_REGS(4), .REG_AW(2), .MEM_WORDS(0), .TIMEOUT(75)) dut1 (
    .clk(clk), .reset(reset1), .start(start1), .rf_addr(rf_addr1), .rf_data(rf_data1),
    .mem_addr(mem_addr1), .mem_data(mem_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_kind(out_kind1), .out_addr(out_addr1), .out_data(out_data1), .busy(busy1),
    .finished(finished1), .cycle_count(cycle_count1));

  // Memories: rf[i] = 3*i, mem window = 0xA0 + word; garbage while a beat is stalled so stray sampling shows up
  assign mem_byte  = {mem_addr, 2'b00};
  assign rf_data   = (out_valid && !out_ready) ? 32'hDEAD0000 ^ 32'(rf_addr) : 32'(rf_addr) * 32'd3;
  assign mem_data  = (out_valid && !out_ready) ? 32'h0BAD0BAD :
                     (mem_byte >= BASE && mem_byte <= BASE + 32'd16) ? 32'hA0 + ((mem_byte - BASE) >> 2) : 32'hFFFFFFFF;
  assign rf_data1  = 32'(rf_addr1) * 32'd3;
  assign mem_data1 = 32'h0;

  int cmp = 0, bad = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    cmp++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  logic [31:0] cyc;
  always @(posedge clk) cyc <= reset ? 32'd0 : cyc + 32'd1;

  beat_t exp_q[$];
  beat_t rx_q[$];
  int nrx, nrx1;
  bit mon = 0, mon1 = 1, seen1 = 0;
  logic [31:0] first_cc, last_cc;

  task automatic build(input int nr, input int nw);
    exp_q.delete();
    for (int i = 0; i < nr; i++) exp_q.push_back('{1'b0, 32'(i), 32'(i) * 3});
    for (int i = 0; i < nw; i++) exp_q.push_back('{1'b1, BASE + 32'(4 * i), 32'hA0 + 32'(i)});
  endtask

  // Any visible beat must be the next one the model expects; acceptance advances the model
  always @(negedge clk) if (mon && out_valid) begin
    if (nrx >= exp_q.size()) chk("beat_overrun", 32'(nrx), 32'(exp_q.size() - 1));
    else begin
      chk("beat_kind", 32'(out_kind), 32'(exp_q[nrx].kind));
      chk("beat_addr", out_addr, exp_q[nrx].addr);
      chk("beat_data", out_data, exp_q[nrx].data);
      if (out_ready) begin
        if (nrx == 0) first_cc = cyc;
        last_cc = cyc;
        rx_q.push_back('{out_kind, out_addr, out_data});
        nrx++;
      end
    end
  end

  always @(negedge clk) if (mon1 && out_valid1) begin
    if (!seen1) chk("timeout_first_cc", cycle_count1, 32'd76);
    seen1 = 1;
    if (nrx1 >= 4) chk("small_overrun", 32'(nrx1), 32'd3);
    else begin
      chk("small_kind", 32'(out_kind1), 32'd0);
      chk("small_addr", out_addr1, 32'(nrx1));
      chk("small_data", out_data1, 32'(nrx1) * 32'd3);
    end
    nrx1++;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic run_dump(input int mode, output logic [31:0] s_cc, output logic [31:0] f_cc);
    nrx = 0;
    rx_q.delete();
    mon = 1;
    s_cc = cyc;
    start = 1;
    for (int k = 0; k < 2000 && !finished; k++) begin
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? (k % 4 == 0 || k % 4 == 3) : 1'($urandom % 2);
      step();
      start = 0;
    end
    f_cc = cyc;
    mon = 0;
    out_ready = 1;
    chk("finished", 32'(finished), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("beat_count", 32'(nrx), 32'(exp_q.size()));
  endtask

  vec_t tbl[4];
  logic [31:0] s_cc, f_cc;

  initial begin
    tbl[0] = '{0, 1'b0, 32'd0, 32'd0};
    tbl[1] = '{31, 1'b0, 32'd31, 32'd93};
    tbl[2] = '{32, 1'b1, 32'h10010000, 32'hA0};
    tbl[3] = '{36, 1'b1, 32'h10010010, 32'hA4};
    reset = 1; reset1 = 1; start = 0; start1 = 0; out_ready = 1; out_ready1 = 1;
    nrx1 = 0;
    repeat (3) step();
    reset = 0; reset1 = 0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_finished", 32'(finished), 32'd0);
    chk("rst_kind", 32'(out_kind), 32'd0);
    chk("rst_addr", out_addr, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_cycles", cycle_count, 32'd0);
    chk("rst_rf_addr", 32'(rf_addr), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);

    while (cyc < 9) step();
    build(32, 5);
    run_dump(0, s_cc, f_cc);
    chk("first_beat_latency", first_cc, s_cc + 32'd2);
    chk("no_bubbles", last_cc, first_cc + 32'd36);
    chk("finished_timing", f_cc, last_cc + 32'd1);
    chk("cycle_count", cycle_count, cyc);
    for (int i = 0; i < 4; i++) begin
      if (tbl[i].idx < rx_q.size()) begin
        chk("tbl_kind", 32'(rx_q[tbl[i].idx].kind), 32'(tbl[i].kind));
        chk("tbl_addr", rx_q[tbl[i].idx].addr, tbl[i].addr);
        chk("tbl_data", rx_q[tbl[i].idx].data, tbl[i].data);
      end else chk("tbl_missing", 32'(rx_q.size()), 32'(tbl[i].idx + 1));
    end

    nrx = 0;
    mon = 1;
    start = 1;
    step();
    start = 0;
    repeat (10) step();
    mon = 0;
    chk("done_start_beats", 32'(nrx), 32'd0);
    chk("done_sticky", 32'(finished), 32'd1);

    while (cyc < 77) step();
    start1 = 1;
    step();
    start1 = 0;
    while (cyc < 90) step();
    mon1 = 0;
    chk("small_beats", 32'(nrx1), 32'd4);
    chk("small_finished", 32'(finished1), 32'd1);
    chk("small_busy", 32'(busy1), 32'd0);

    do_reset();
    nrx = 0;
    mon = 1;
    start = 1;
    step();
    start = 0;
    for (int k = 0; k < 100 && nrx < 20; k++) step();
    reset = 1;
    mon = 0;
    step();
    reset = 0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_finished", 32'(finished), 32'd0);
    chk("abort_cycles", cycle_count, 32'd0);
    run_dump(0, s_cc, f_cc);
    chk("replay_first_addr", rx_q.size() > 0 ? rx_q[0].addr : 32'hFFFFFFFF, 32'd0);

    do_reset();
    run_dump(1, s_cc, f_cc);
    do_reset();
    run_dump(2, s_cc, f_cc);

    force dut.cnt_q = 32'hFFFFFFFD;
    #1;
    release dut.cnt_q;
    step();
    chk("sat_fe", cycle_count, 32'hFFFFFFFE);
    step();
    chk("sat_ff", cycle_count, 32'hFFFFFFFF);
    repeat (3) step();
    chk("sat_hold", cycle_count, 32'hFFFFFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
